// File: rtl/pretu_tile_fetch_if.sv
// rtl/pretu_tile_fetch_if.sv - pixel-in / column-vector-out handshake bundle for pretu_tile_fetch
interface pretu_tile_fetch_if #(
    parameter int DW = 16,
    parameter int CW = 4,
    parameter int RW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_pix;
    logic          o_valid;
    logic          o_ready;
    logic [DW-1:0] o_x0;
    logic [DW-1:0] o_x1;
    logic [DW-1:0] o_x2;
    logic [DW-1:0] o_x3;
    logic [CW-1:0] o_col;
    logic [RW-1:0] o_vt;
    logic          o_last;

    modport slave (
        input  in_valid, in_pix, o_ready,
        output in_ready, o_valid, o_x0, o_x1, o_x2, o_x3, o_col, o_vt, o_last
    );

    modport master (
        output in_valid, in_pix, o_ready,
        input  in_ready, o_valid, o_x0, o_x1, o_x2, o_x3, o_col, o_vt, o_last
    );
endinterface

// File: rtl/pretu_tile_fetch.sv
// rtl/pretu_tile_fetch.sv - three-row line buffer emitting 4-row, stride-2 column vectors
module pretu_tile_fetch #(
    parameter int DW    = 16,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic                  clk,
    input  logic                  rst,
    pretu_tile_fetch_if.slave     bus
);
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic          o_valid_q, o_valid_d;
    logic [DW-1:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
    logic [CW-1:0] ocol_q, ocol_d;
    logic [RW-1:0] vt_q, vt_d;
    logic          last_q, last_d;

    // Column-indexed history: lb0 = row r-3, lb1 = row r-2, lb2 = row r-1.
    logic [DW-1:0] lb0_q [IMG_W];
    logic [DW-1:0] lb1_q [IMG_W];
    logic [DW-1:0] lb2_q [IMG_W];

    logic          in_ready;
    logic          accept;
    logic          emit;
    logic          last_col;
    logic          last_row;
    logic [DW-1:0] rd_a, rd_b, rd_d;

    assign in_ready = !o_valid_q || bus.o_ready;
    assign accept   = bus.in_valid && in_ready;
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));
    assign emit     = accept && row_q[0] && (row_q >= RW'(3));

    assign rd_a = lb0_q[col_q];
    assign rd_b = lb1_q[col_q];
    assign rd_d = lb2_q[col_q];

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_comb begin
        o_valid_d = o_valid_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        x3_d      = x3_q;
        ocol_d    = ocol_q;
        vt_d      = vt_q;
        last_d    = last_q;
        if (emit) begin
            o_valid_d = 1'b1;
            x0_d      = rd_a;
            x1_d      = rd_b;
            x2_d      = rd_d;
            x3_d      = bus.in_pix;
            ocol_d    = col_q;
            vt_d      = RW'((row_q - RW'(3)) >> 1);
            last_d    = last_row && last_col;
        end else if (bus.o_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            o_valid_q <= 1'b0;
            x0_q      <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            x3_q      <= '0;
            ocol_q    <= '0;
            vt_q      <= '0;
            last_q    <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            o_valid_q <= o_valid_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            x3_q      <= x3_d;
            ocol_q    <= ocol_d;
            vt_q      <= vt_d;
            last_q    <= last_d;
        end
    end

    // Not reset: rows 0..2 of every frame rewrite each column before it is read out.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_q[col_q] <= rd_b;
            lb1_q[col_q] <= rd_d;
            lb2_q[col_q] <= bus.in_pix;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.o_valid  = o_valid_q;
    assign bus.o_x0     = x0_q;
    assign bus.o_x1     = x1_q;
    assign bus.o_x2     = x2_q;
    assign bus.o_x3     = x3_q;
    assign bus.o_col    = ocol_q;
    assign bus.o_vt     = vt_q;
    assign bus.o_last   = last_q;
endmodule

// File: tb/tb_pretu_tile_fetch.sv
// tb/tb_pretu_tile_fetch.sv - randomized model-checked bench for pretu_tile_fetch (4x6 frames)
module tb_pretu_tile_fetch;
    localparam int W = 4;
    localparam int H = 6;

    typedef struct packed {
        logic [15:0] x0;
        logic [15:0] x1;
        logic [15:0] x2;
        logic [15:0] x3;
        logic [1:0]  col;
        logic [2:0]  vt;
        logic        last;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pretu_tile_fetch_if #(.DW(16), .CW(2), .RW(3)) bus ();

    pretu_tile_fetch #(.DW(16), .IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: frame pixels seen so far and the single pending output vector.
    logic [15:0] pix_mem [H][W];
    logic [15:0] gen     [H][W];
    logic [15:0] sgn     [4];
    vec_t        log_q   [$];
    vec_t        m_vec;
    vec_t        prev_vec;
    logic        m_valid;
    logic        prev_stall;
    logic        lat_pending;
    logic        arm_lat;
    int          m_row;
    int          m_col;

    function automatic vec_t dut_vec();
        return {bus.o_x0, bus.o_x1, bus.o_x2, bus.o_x3, bus.o_col, bus.o_vt, bus.o_last};
    endfunction

    function automatic vec_t ramp_vec(input int i);
        int r, c;
        r = 3 + 2 * (i / W);
        c = i % W;
        return {16'(16 * (r - 3) + c), 16'(16 * (r - 2) + c), 16'(16 * (r - 1) + c),
                16'(16 * r + c), 2'(c), 3'((r - 3) / 2), (r == H - 1) && (c == W - 1)};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [15:0] p, input logic rdy, output logic acc);
        vec_t dv;
        logic exp_rdy;
        logic cons;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_pix   = p;
        bus.o_ready  = rdy;
        #1;
        dv      = dut_vec();
        exp_rdy = !m_valid || rdy;
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("o_valid", bus.o_valid, m_valid);
        if (m_valid) chk("vector", dv, m_vec);
        if (prev_stall) chk("hold_stable", dv, prev_vec);
        if (lat_pending) begin
            chk("latency_r3c1", {bus.o_valid, dv},
                {1'b1, 16'd1, 16'd17, 16'd33, 16'd49, 2'd1, 3'd0, 1'b0});
            lat_pending = 1'b0;
        end
        cons = m_valid && rdy;
        if (cons) log_q.push_back(dv);
        prev_stall = m_valid && !rdy;
        prev_vec   = dv;
        acc = v && exp_rdy;
        if (acc) begin
            pix_mem[m_row][m_col] = p;
            if (m_row >= 3 && (m_row % 2) == 1) begin
                m_vec = {pix_mem[m_row-3][m_col], pix_mem[m_row-2][m_col], pix_mem[m_row-1][m_col], p,
                         2'(m_col), 3'((m_row - 3) / 2), (m_row == H - 1) && (m_col == W - 1)};
                m_valid = 1'b1;
                if (arm_lat && m_row == 3 && m_col == 1) lat_pending = 1'b1;
            end else if (cons) begin
                m_valid = 1'b0;
            end
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
        end else if (cons) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.o_ready  = 1'b0;
        #1;
        chk("rst_o_valid", bus.o_valid, 1'b0);
        chk("rst_outputs", dut_vec(), '0);
        m_valid     = 1'b0;
        m_row       = 0;
        m_col       = 0;
        prev_stall  = 1'b0;
        lat_pending = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_frame(input int mode, input int stall_at, input int stop_at, input bit rnd);
        logic [15:0] p;
        logic        acc;
        logic        v;
        logic        rdy;
        int          tries;
        int          r;
        int          c;
        for (int idx = 0; idx < W * H; idx++) begin
            if (idx == stop_at) return;
            r = idx / W;
            c = idx % W;
            case (mode)
                0:       p = 16'(16 * r + c);
                1:       p = (c == 0 && r < 4) ? sgn[r] : 16'($urandom);
                default: p = 16'($urandom);
            endcase
            gen[r][c] = p;
            acc = 1'b0;
            if (idx == stall_at) begin
                for (int k = 0; k < 5; k++) if (!acc) cycle(1'b1, p, 1'b0, acc);
            end
            tries = 0;
            while (!acc && tries < 200) begin
                v   = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
                rdy = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
                cycle(v, p, rdy, acc);
                tries++;
            end
            if (!acc) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=not_accepted required=accepted idx=%0d", idx);
            end
        end
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 3; k++) cycle(1'b0, 16'd0, 1'b1, acc);
    endtask

    task automatic check_ramp_frame(input int base, input string nm);
        chk({nm, "_count"}, log_q.size() - base, 8);
        for (int i = 0; i < 8; i++)
            if (base + i < log_q.size()) chk({nm, "_vec"}, log_q[base+i], ramp_vec(i));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base;
        checks       = 0;
        failures     = 0;
        arm_lat      = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_pix   = '0;
        bus.o_ready  = 1'b0;
        sgn[0] = 16'h8000;
        sgn[1] = 16'h7fff;
        sgn[2] = 16'hffff;
        sgn[3] = 16'h0000;
        do_reset();

        // Ramp frame with free flow, literal spot checks pin the model.
        base    = log_q.size();
        arm_lat = 1'b1;
        run_frame(0, -1, -1, 1'b0);
        arm_lat = 1'b0;
        drain();
        chk("basic_count", log_q.size() - base, 8);
        if (log_q.size() >= base + 8) begin
            chk("basic_first", log_q[base],
                {16'd0, 16'd16, 16'd32, 16'd48, 2'd0, 3'd0, 1'b0});
            chk("basic_r5c2", log_q[base+6],
                {16'd34, 16'd50, 16'd66, 16'd82, 2'd2, 3'd1, 1'b0});
            chk("basic_last", log_q[base+7].last, 1'b1);
        end

        // Five-cycle downstream stall while the row-3 col-2 vector is pending.
        base = log_q.size();
        run_frame(0, 15, -1, 1'b0);
        drain();
        check_ramp_frame(base, "stall");

        // Signed extremes in column 0.
        base = log_q.size();
        run_frame(1, -1, -1, 1'b0);
        drain();
        chk("signed_count", log_q.size() - base, 8);
        if (log_q.size() > base)
            chk("signed_vec", log_q[base],
                {16'h8000, 16'h7fff, 16'hffff, 16'h0000, 2'd0, 3'd0, 1'b0});

        // Two frames with no gap.
        base = log_q.size();
        run_frame(2, -1, -1, 1'b0);
        run_frame(2, -1, -1, 1'b0);
        drain();
        chk("b2b_count", log_q.size() - base, 16);
        if (log_q.size() > base + 8)
            chk("b2b_frame2_first", log_q[base+8],
                {gen[0][0], gen[1][0], gen[2][0], gen[3][0], 2'd0, 3'd0, 1'b0});

        // Random valid/ready on both sides over two frames.
        base = log_q.size();
        run_frame(2, -1, -1, 1'b1);
        run_frame(2, -1, -1, 1'b1);
        drain();
        chk("rand_count", log_q.size() - base, 16);

        // Reset with the row-4 col-1 pixel about to be presented, then a fresh frame.
        run_frame(0, -1, 17, 1'b0);
        do_reset();
        base = log_q.size();
        run_frame(0, -1, -1, 1'b0);
        drain();
        check_ramp_frame(base, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
